// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Arbitrates two CPU ports (A: instruction reads, B: data reads/writes)
//   onto a single backing-memory port. One transaction is in flight at a
//   time. Ties are broken round-robin.
//
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     read_a, address_a          port A request (held until resp_a)
//     resp_a, rdata_a            port A completion pulse / read word
//     read_b, write, wmask,
//     address_b, wdata           port B request (held until resp_b)
//     resp_b, rdata_b            port B completion pulse / read word
//     mem_read, mem_write,
//     mem_address, mem_wdata,
//     mem_wmask                  backing-memory request (held until mem_resp)
//     mem_resp, mem_rdata        backing-memory completion / read word
module cpu_mem_responder #(
  parameter bit FIRST_GRANT = 1'b0  // 0: port A wins the first tie, 1: port B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, MEM_A, MEM_B, DONE_A, DONE_B} state_t;

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;   // 1: port B received the most recent grant
  logic        pend_a, pend_b, grant_b;
  logic        resp_a_d, resp_b_d, mem_read_d, mem_write_d;
  logic [31:0] rdata_a_d, rdata_b_d, addr_d, wdata_d;
  logic [3:0]  wmask_d;

  // Memory is word addressed; the byte-offset bits are dropped on purpose.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, address_a[1:0], address_b[1:0]};

  assign pend_a  = read_a;
  assign pend_b  = read_b | write;
  // B wins when alone, or on a tie when A was granted last.
  assign grant_b = pend_b & (~pend_a | ~last_b_q);

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    resp_a_d    = 1'b0;
    resp_b_d    = 1'b0;
    rdata_a_d   = rdata_a;
    rdata_b_d   = rdata_b;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    addr_d      = mem_address;
    wdata_d     = mem_wdata;
    wmask_d     = mem_wmask;
    case (state_q)
      IDLE: begin
        if (pend_a | pend_b) begin
          // The mem_* registers double as the latched request, so a port
          // changing its inputs mid-transaction cannot disturb the access.
          last_b_d    = grant_b;
          state_d     = grant_b ? MEM_B : MEM_A;
          addr_d      = grant_b ? {address_b[31:2], 2'b00} : {address_a[31:2], 2'b00};
          wdata_d     = grant_b ? wdata : 32'h0;
          wmask_d     = grant_b ? wmask : 4'h0;
          // write takes precedence over a simultaneous read_b
          mem_write_d = grant_b & write;
          mem_read_d  = ~(grant_b & write);
        end
      end
      MEM_A: begin
        if (mem_resp) begin
          mem_read_d = 1'b0;
          resp_a_d   = 1'b1;
          rdata_a_d  = mem_rdata;
          state_d    = DONE_A;
        end
      end
      MEM_B: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          resp_b_d    = 1'b1;
          rdata_b_d   = mem_write ? 32'h0 : mem_rdata;
          state_d     = DONE_B;
        end
      end
      // One dead cycle after completion: a still-held request is only
      // sampled again once back in IDLE.
      DONE_A, DONE_B: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= ~FIRST_GRANT;
      resp_a      <= 1'b0;
      resp_b      <= 1'b0;
      rdata_a     <= 32'h0;
      rdata_b     <= 32'h0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wmask   <= 4'h0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      resp_a      <= resp_a_d;
      resp_b      <= resp_b_d;
      rdata_a     <= rdata_a_d;
      rdata_b     <= rdata_b_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      mem_address <= addr_d;
      mem_wdata   <= wdata_d;
      mem_wmask   <= wmask_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
//   Directed and randomized checks of cpu_mem_responder against a word-array
//   reference model with a round-robin grant predictor. A behavioural backing
//   memory with programmable latency answers the DUT's memory port.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_a, read_b, write;
  logic [31:0] address_a, address_b, wdata;
  logic [3:0]  wmask;
  logic        resp_a, resp_b, mem_read, mem_write;
  logic [31:0] rdata_a, rdata_b, mem_address, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.FIRST_GRANT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } acc_t;

  // backing memory (environment) and reference model share a 256-word window
  logic [31:0] env_mem [256] = '{1: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] ref_mem [256] = '{1: 32'hDEADBEEF, default: 32'h0};
  acc_t        acc_q[$];
  int          lat  = 0;
  bit          tied = 1'b0;
  int          cnt  = 0;
  bit          both_seen = 1'b0;
  bit          last_b = 1'b1;   // model: port that won the last grant
  int          total = 0, passed = 0;

  always @(negedge clk) begin
    if (resp_a && resp_b) both_seen <= 1'b1;
    if (!rst_n) begin
      mem_resp <= 1'b0;
      cnt      <= 0;
    end else if (tied) begin
      mem_resp  <= 1'b1;
      mem_rdata <= env_mem[mem_address[9:2]];
    end else if (mem_resp) begin
      mem_resp <= 1'b0;
    end else if (mem_read || mem_write) begin
      if (cnt >= lat) begin
        cnt      <= 0;
        mem_resp <= 1'b1;
        acc_q.push_back('{mem_read, mem_write, mem_address, mem_wdata, mem_wmask});
        if (mem_write) begin
          for (int i = 0; i < 4; i++)
            if (mem_wmask[i]) env_mem[mem_address[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end else begin
          mem_rdata <= env_mem[mem_address[9:2]];
        end
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    for (int i = 0; i < 4; i++)
      if (wm[i]) ref_mem[addr[9:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  // waits (bounded) for the next completion pulse; port=-1 on timeout
  task automatic wait_resp(output int port, output int cyc);
    port = -1;
    cyc  = 0;
    while (port < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_a) port = 0;
      else if (resp_b) port = 1;
    end
  endtask

  task automatic check_acc(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] wm);
    acc_t a;
    chk({tag, ".acc_cnt"}, acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      a = acc_q.pop_front();
      chk({tag, ".mem_addr"}, a.addr, {addr[31:2], 2'b00});
      chk({tag, ".mem_op"}, {a.rd, a.wr}, {~wr, wr});
      if (wr) chk({tag, ".mem_wd"}, {a.wdata, a.wmask}, {wd, wm});
    end
    acc_q.delete();
  endtask

  // single transaction from an idle start; call right after a negedge
  task automatic do_op(input string tag, input bit pb, input bit wr, input bit rdb,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm,
                       output int cyc);
    logic [31:0] exp_d;
    int port;
    bit is_wr;
    is_wr = pb & wr;
    if (is_wr) begin
      exp_d = 32'h0;
      ref_write(addr, wd, wm);
    end else begin
      exp_d = ref_mem[addr[9:2]];
    end
    last_b = pb;
    if (pb) begin
      read_b = rdb | ~wr; write = wr; address_b = addr; wdata = wd; wmask = wm;
    end else begin
      read_a = 1'b1; address_a = addr;
    end
    wait_resp(port, cyc);
    chk({tag, ".port"}, port, pb);
    chk({tag, ".rdata"}, pb ? rdata_b : rdata_a, exp_d);
    check_acc(tag, is_wr, addr, wd, wm);
    read_a = 1'b0; read_b = 1'b0; write = 1'b0;
  endtask

  // both ports request in the same cycle; B optionally writes
  task automatic do_pair(input string tag, input bit wr, input logic [31:0] aa,
                         input logic [31:0] ab, input logic [31:0] wd, input logic [3:0] wm);
    bit first_b;
    bit eb;
    logic [31:0] exp_a, exp_b;
    int port, cyc;
    first_b = ~last_b;
    if (first_b) begin
      exp_b = wr ? 32'h0 : ref_mem[ab[9:2]];
      if (wr) ref_write(ab, wd, wm);
      exp_a = ref_mem[aa[9:2]];
    end else begin
      exp_a = ref_mem[aa[9:2]];
      exp_b = wr ? 32'h0 : ref_mem[ab[9:2]];
      if (wr) ref_write(ab, wd, wm);
    end
    last_b = ~first_b;
    read_a = 1'b1; address_a = aa;
    read_b = ~wr; write = wr; address_b = ab; wdata = wd; wmask = wm;
    for (int k = 0; k < 2; k++) begin
      eb = (k == 0) ? first_b : ~first_b;
      wait_resp(port, cyc);
      chk({tag, ".order"}, port, eb);
      if (port == 1) begin
        chk({tag, ".rdata_b"}, rdata_b, exp_b);
        read_b = 1'b0; write = 1'b0;
      end else if (port == 0) begin
        chk({tag, ".rdata_a"}, rdata_a, exp_a);
        read_a = 1'b0;
      end
    end
    chk({tag, ".acc_cnt"}, acc_q.size(), 2);
    acc_q.delete();
    read_a = 1'b0; read_b = 1'b0; write = 1'b0;
  endtask

  initial begin
    int cyc, port, nresp, nrise, prev_pos;
    bit prev_rd;
    bit exp_b;
    logic [31:0] a;
    rst_n = 1'b0; read_a = 1'b0; read_b = 1'b0; write = 1'b0;
    address_a = 32'h0; address_b = 32'h0; wdata = 32'h0; wmask = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {resp_a, resp_b, mem_read, mem_write, rdata_a, rdata_b, mem_wmask}, 64'h0);
    chk("reset_addr_wdata", {mem_address, mem_wdata}, 64'h0);
    rst_n = 1'b1;

    // port A read, three-cycle memory latency, unaligned byte address
    lat = 3;
    do_op("rd_a_1006", 1'b0, 1'b0, 1'b0, 32'h0000_1006, 32'h0, 4'h0, cyc);
    chk("rd_a_1006.latency", cyc, 5);
    @(negedge clk);
    chk("rd_a_1006.resp_one_cycle", resp_a, 1'b0);
    chk("rd_a_1006.rdata_hold", rdata_a, 32'hDEADBEEF);

    // port B writes: partial mask, write+read_b together, empty mask
    lat = 0;
    do_op("wr_b_40", 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678, 4'b0011, cyc);
    chk("wr_b_40.min_latency", cyc, 2);
    do_op("wr_rd_b", 1'b1, 1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 4'b1111, cyc);
    do_op("wr_mask0", 1'b1, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 4'b0000, cyc);
    do_op("rd_b_40", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, cyc);

    // fresh reset, both ports held: grants must alternate starting with A
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_b = 1'b1;
    read_a = 1'b1; address_a = 32'h40;
    read_b = 1'b1; address_b = 32'h44;
    for (int k = 0; k < 4; k++) begin
      exp_b = ~last_b;
      last_b = exp_b;
      wait_resp(port, cyc);
      chk("tie_alternate.order", port, exp_b);
      if (port == 1) chk("tie_alternate.rdata_b", rdata_b, ref_mem[8'h11]);
      else           chk("tie_alternate.rdata_a", rdata_a, ref_mem[8'h10]);
    end
    read_a = 1'b0; read_b = 1'b0;
    acc_q.delete();

    // mem_resp tied high with read_a held: one completion every 3 cycles
    @(negedge clk);
    tied = 1'b1;
    read_a = 1'b1; address_a = 32'h0000_1004;
    nresp = 0; nrise = 0; prev_rd = 1'b0; prev_pos = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_read && !prev_rd) nrise++;
      prev_rd = mem_read;
      if (resp_a) begin
        nresp++;
        if (prev_pos >= 0) chk("tied.resp_gap", i - prev_pos, 3);
        else chk("tied.rdata", rdata_a, 32'hDEADBEEF);
        prev_pos = i;
      end
    end
    read_a = 1'b0;
    tied = 1'b0;
    last_b = 1'b0;
    chk("tied.resp_count", nresp, 4);
    chk("tied.access_count", nrise, 4);
    repeat (2) @(negedge clk);
    acc_q.delete();

    // reset in the middle of a port B write
    lat = 20;
    write = 1'b1; read_b = 1'b0; address_b = 32'h80; wdata = 32'hA5A5_5A5A; wmask = 4'hF;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_write && cyc < 5);
    chk("rst_mid.mem_write_up", mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.mem_write_async_drop", mem_write, 1'b0);
    chk("rst_mid.no_resp", resp_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_b = 1'b1;
    lat = 1;
    ref_write(32'h80, 32'hA5A5_5A5A, 4'hF);
    wait_resp(port, cyc);
    chk("rst_mid.reissue_port", port, 1);
    chk("rst_mid.reissue_rdata", rdata_b, 32'h0);
    check_acc("rst_mid", 1'b1, 32'h80, 32'hA5A5_5A5A, 4'hF);
    write = 1'b0;
    nresp = 0;
    repeat (4) begin @(negedge clk); if (resp_b) nresp++; end
    chk("rst_mid.single_ack", nresp, 0);
    chk("rst_mid.mem_value", ref_mem[8'h20], 32'hA5A5_5A5A);

    // randomized singles and ties
    for (int it = 0; it < 40; it++) begin
      lat = $urandom_range(0, 3);
      a = $urandom & 32'h3FF;
      if ($urandom_range(0, 2) == 0)
        do_pair("rnd_pair", 1'($urandom_range(0, 1)), $urandom & 32'h3FF, a,
                $urandom, 4'($urandom));
      else
        do_op("rnd_op", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), cyc);
    end

    repeat (2) @(negedge clk);
    chk("never_both_resp", both_seen, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter FIRST_GRANT, default 0; port granted first when both request after reset (0 = port A, 1 = port B).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 read_a  in  1  CPU port A (instruction) read request; held until resp_a.
REQ-005 address_a  in  32  port A byte address.
REQ-006 resp_a  out  1  port A one-cycle completion pulse.
REQ-007 rdata_a  out  32  port A read word; valid while resp_a=1.
REQ-008 read_b  in  1  port B (data) read request; held until resp_b.
REQ-009 write  in  1  port B write request; held until resp_b.
REQ-010 wmask  in  4  port B byte enables; bit i covers wdata[8i+7:8i].
REQ-011 address_b  in  32  port B byte address.
REQ-012 wdata  in  32  port B write word.
REQ-013 resp_b  out  1  port B one-cycle completion pulse.
REQ-014 rdata_b  out  32  port B read word; valid while resp_b=1.
REQ-015 mem_read  out  1  backing-memory read strobe; held until mem_resp.
REQ-016 mem_write  out  1  backing-memory write strobe; held until mem_resp.
REQ-017 mem_address  out  32  word address, {addr[31:2],2'b00}.
REQ-018 mem_wdata  out  32  write data to backing memory.
REQ-019 mem_wmask  out  4  byte enables to backing memory.
REQ-020 mem_resp  in  1  backing-memory completion, one cycle.
REQ-021 mem_rdata  in  32  backing-memory read word; valid with mem_resp.

Function
REQ-022 FSM states: IDLE, MEM_A, MEM_B, DONE_A, DONE_B; all outputs registered.
REQ-023 IDLE: only read_a pending -> MEM_A; only read_b or write pending -> MEM_B; none -> stay IDLE.
REQ-024 IDLE, both ports pending: grant port not granted last (round-robin); last_grant updates on every grant.
REQ-025 Entering MEM_x: latch port address/wdata/wmask/op into internal registers; mem_* driven from latched values only.
REQ-026 MEM_A: mem_read=1, mem_write=0; MEM_B: mem_write=write, mem_read=~write.
REQ-027 write=1 and read_b=1 together: treated as write; read ignored.
REQ-028 write with wmask=4'b0000: still issued to memory and acknowledged normally.
REQ-029 MEM_x with mem_resp=1: capture mem_rdata (reads), drop mem_* strobes next cycle, go DONE_x.
REQ-030 DONE_x: resp_x=1 for exactly one cycle, rdata_x=captured word (0 for writes); next state IDLE.
REQ-031 Minimum latency: request sampled in IDLE cycle 0 -> mem strobe cycle 1 -> mem_resp cycle 1 earliest -> resp_x cycle 2.
REQ-032 Request seen in DONE_x is not sampled; sampled only in IDLE the following cycle (no double-service of a held request).
REQ-033 Requests arriving/changing during MEM_x for the other port wait; no effect on in-flight transaction.
REQ-034 resp_a and resp_b never asserted in the same cycle; at most one mem transaction outstanding.
REQ-035 mem_resp in IDLE or DONE_x: ignored.
REQ-036 rdata_a/rdata_b hold last value outside resp cycles.

Reset
REQ-037 rst_n=0 (async): state IDLE; resp_a, resp_b, mem_read, mem_write=0; rdata_a, rdata_b, mem_address, mem_wdata, mem_wmask=0; last_grant set so FIRST_GRANT port wins next tie.
REQ-038 Reset mid-transaction: in-flight access abandoned, no resp issued; mem_resp after rst_n release ignored unless in MEM_x.

Verification
REQ-039 read_a=1, address_a=0x0000_1006; mem_resp after 3 cycles with mem_rdata=0xDEADBEEF -> mem_address=0x0000_1004, resp_a one cycle, rdata_a=0xDEADBEEF.
REQ-040 write=1, address_b=0x40, wdata=0x12345678, wmask=4'b0011 -> mem_write=1, mem_wmask=0011, mem_wdata=0x12345678; resp_b one cycle; rdata_b=0.
REQ-041 read_a and read_b asserted same cycle after reset, held, FIRST_GRANT=0 -> A served first, then B; third tie -> A (alternation).
REQ-042 mem_resp tied high, read_a held continuously -> resp_a every 3 cycles, never back-to-back, no extra access.
REQ-043 rst_n pulsed low during MEM_B -> mem_write drops asynchronously, no resp_b; after release, held write reissued and acknowledged once.
REQ-044 write=1 and read_b=1 simultaneously -> only mem_write asserted; mem_read stays 0.
